phase_synthesizer: RTL and testbench
====================================

// Module: phase_synthesizer
// PURPOSE
//   Synthesis-side counterpart of the phase detector. Consumes detector phase pairs
//   (phase, phase_last) at the detected peak bin. Scales the inter-window phase advance
//   and the bin index by a pitch ratio, then accumulates a running synthesis phase.
//   Emits one full polar DFT frame as an AXI4-Stream master toward the polar->cartesian
//   CORDIC and IFFT.
// PARAMETERS
//   ADDR_WIDTH   11  log2(frame length N); N = 2**ADDR_WIDTH bins per frame
//   PHASE_WIDTH  24  two's-complement phase width, full scale +/-pi; must be <= 24
//   MAG_WIDTH    16  unsigned magnitude width; must be <= 24
//   RATIO_WIDTH  16  unsigned pitch ratio width
//   RATIO_FRAC   12  fractional bits of pitch_ratio (0x1000 = 1.0)
// PORTS
//   clock          in   1            system clock, all logic rising-edge
//   reset          in   1            asynchronous, active-high reset
//   phase          in   PHASE_WIDTH  current-window phase at k_max
//   phase_last     in   PHASE_WIDTH  previous-window phase at k_max
//   phases_valid   in   1            single-cycle strobe qualifying phase/phase_last/k_max/magnitude
//   k_max          in   ADDR_WIDTH   analysis peak bin index
//   magnitude      in   MAG_WIDTH    peak magnitude to synthesize
//   pitch_ratio    in   RATIO_WIDTH  pitch-shift factor, sampled with phases_valid
//   m_tdata        out  48           {mag zero-ext to 24, phase sign-ext to 24}
//   m_tvalid       out  1            stream valid
//   m_tready       in   1            stream ready (downstream backpressure)
//   m_tlast        out  1            high on bin N-1 beat
//   m_tuser        out  16           bin index of current beat, zero-extended
//   busy           out  1            high from capture until the final handshake
//   dropped_count  out  8            saturating count of phases_valid strobes ignored while busy
// BEHAVIOUR
//   Reset values: m_tdata=0, m_tvalid=0, m_tlast=0, m_tuser=0, busy=0, dropped_count=0.
//     Phase accumulator acc=0. State=IDLE. Reset acts immediately, including mid-frame;
//     no tlast is issued for an aborted frame.
//   FSM states: IDLE -> CAPTURE -> SCALE -> ACCUM -> STREAM -> IDLE.
//   IDLE: on phases_valid, register all inputs, go to CAPTURE, set busy=1.
//   CAPTURE: delta = phase - phase_last, modulo 2**PHASE_WIDTH (natural wrap).
//   SCALE: compute the following.
//     - prod = signed(delta) * unsigned(pitch_ratio), arithmetic >> RATIO_FRAC,
//       truncated to PHASE_WIDTH (wrap, no saturation).
//     - k_out = (k_max * pitch_ratio) >> RATIO_FRAC, saturated to N/2-1.
//   ACCUM: acc <= acc + prod (wrap). Enter STREAM with m_tvalid=1 and m_tuser=0.
//   Latency: phases_valid sampled at edge E; first m_tvalid is high after edge E+4.
//   STREAM: one beat per bin, m_tuser 0..N-1.
//     - Bin k_out: {magnitude, acc}.
//     - k_out==0: bin 0 carries {magnitude, 0}.
//     - All other bins: 48'h0.
//   AXI rules: m_tdata, m_tuser and m_tlast are held stable while m_tvalid && !m_tready.
//     m_tuser advances only on a handshake. m_tlast=1 only with m_tuser=N-1. After the
//     N-1 handshake: m_tvalid=0, busy=0, return to IDLE. A new frame may be captured on
//     the following cycle.
//   phases_valid while busy (any non-IDLE state): ignored; dropped_count += 1, saturating
//     at 255. Captured values are unaffected.
//   acc persists across frames and is cleared only by reset.
// CONFIGURATION
//   PHASE_SYNTH_HERMITIAN_EN defined: also emit the mirror bin N-k_out with
//     {magnitude, -acc}, so the IFFT output is real. No mirror when k_out==0.
//   Not defined: only bin k_out is nonzero.
// TESTING
//   1. phase=0x000400, phase_last=0x000100, ratio=0x1000, k_max=10, mag=0x1234, tready=1
//      -> 2048 beats; bin 10 = {0x001234, 0x000300}; tlast on tuser 2047;
//      with HERMITIAN_EN, bin 2038 = {0x001234, 0xFFFD00}.
//   2. Two frames with delta=0x000300, ratio=0x2000, k_max=10
//      -> k_out=20; acc=0x000600 in frame 1, 0x000C00 in frame 2.
//   3. phase=0x800100, phase_last=0x7FFF00, ratio=1.0 -> delta wraps to 0x000200.
//      k_max=1500, ratio=0x2000 -> k_out saturates to 1023.
//   4. m_tready pseudo-random at 50% -> exactly 2048 handshakes, tuser strictly sequential,
//      data stable during stalls.
//   5. phases_valid pulsed 3x during STREAM -> dropped_count=3; frame contents unchanged.
//   6. reset asserted at beat 500 -> m_tvalid=0 immediately. The next frame starts at
//      tuser 0 and its acc equals only that frame's prod.

Source files
------------

// File: rtl/phase_synthesizer_if.sv
// AXI4-Stream polar-frame bus between the phase synthesizer and the polar->cartesian stage.
interface phase_synthesizer_if;
  logic [47:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [15:0] m_tuser;

  // Handshake: a beat transfers on a rising edge where m_tvalid && m_tready.
  // Once m_tvalid is high, tdata/tuser/tlast hold until that transfer.
  modport master (output m_tdata, output m_tvalid, output m_tlast, output m_tuser, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, input m_tuser, output m_tready);
endinterface

// File: rtl/phase_synthesizer.sv
// Scales the detected peak's phase advance and bin by a pitch ratio, accumulates phase and streams one polar frame.
// Optional macro PHASE_SYNTH_HERMITIAN_EN also emits the conjugate mirror bin N-k_out.
module phase_synthesizer #(
  parameter int ADDR_WIDTH  = 11,
  parameter int PHASE_WIDTH = 24,
  parameter int MAG_WIDTH   = 16,
  parameter int RATIO_WIDTH = 16,
  parameter int RATIO_FRAC  = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PHASE_WIDTH-1:0] phase,
  input  logic [PHASE_WIDTH-1:0] phase_last,
  input  logic                   phases_valid,
  input  logic [ADDR_WIDTH-1:0]  k_max,
  input  logic [MAG_WIDTH-1:0]   magnitude,
  input  logic [RATIO_WIDTH-1:0] pitch_ratio,
  phase_synthesizer_if.master    m_axis,
  output logic                   busy,
  output logic [7:0]             dropped_count,
  output logic [2:0]             dbg_state
);
  localparam int PROD_W = PHASE_WIDTH + RATIO_WIDTH + 1;
  localparam int KP_W   = ADDR_WIDTH + RATIO_WIDTH;
  localparam logic [KP_W-1:0] K_SAT = KP_W'((2 ** ADDR_WIDTH) / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] BIN_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SCALE, S_ACCUM, S_STREAM} state_t;

  state_t state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d, phase_last_q, phase_last_d;
  logic [ADDR_WIDTH-1:0]  k_max_q, k_max_d, k_out_q, k_out_d, tuser_q, tuser_d;
  logic [MAG_WIDTH-1:0]   mag_q, mag_d;
  logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
  logic signed [PHASE_WIDTH-1:0] delta_q, delta_d, prod_q, prod_d, acc_q, acc_d;
  logic [47:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d;
  logic [7:0]  drop_q, drop_d;

  logic signed [PROD_W-1:0]      prod_full, prod_shift;
  logic [KP_W-1:0]               k_full, k_shift;
  logic [ADDR_WIDTH-1:0]         beat_bin;
  logic [MAG_WIDTH-1:0]          mag_sel;
  logic signed [PHASE_WIDTH-1:0] ph_sel;
  logic [47:0]                   beat_data;

  // Datapath: scaling products and the contents of the next beat to load.
  always_comb begin
    prod_full  = PROD_W'(delta_q) * $signed(PROD_W'(ratio_q));
    prod_shift = prod_full >>> RATIO_FRAC;
    k_full     = KP_W'(k_max_q) * KP_W'(ratio_q);
    k_shift    = k_full >> RATIO_FRAC;
    beat_bin   = tvalid_q ? tuser_q + ADDR_WIDTH'(1) : '0;
    mag_sel    = '0;
    ph_sel     = '0;
    if (beat_bin == k_out_q) begin
      mag_sel = mag_q;
      ph_sel  = (k_out_q == '0) ? '0 : acc_q;
    end
`ifdef PHASE_SYNTH_HERMITIAN_EN
    else if ((k_out_q != '0) && (beat_bin == ADDR_WIDTH'(0) - k_out_q)) begin
      mag_sel = mag_q;
      ph_sel  = -acc_q;
    end
`endif
    beat_data = {24'(mag_sel), 24'(ph_sel)};
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    phase_last_d = phase_last_q;
    k_max_d      = k_max_q;
    mag_d        = mag_q;
    ratio_d      = ratio_q;
    delta_d      = delta_q;
    prod_d       = prod_q;
    k_out_d      = k_out_q;
    acc_d        = acc_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    busy_d       = busy_q;
    drop_d       = drop_q;

    if (phases_valid && (state_q != S_IDLE) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (phases_valid) begin
          phase_d      = phase;
          phase_last_d = phase_last;
          k_max_d      = k_max;
          mag_d        = magnitude;
          ratio_d      = pitch_ratio;
          busy_d       = 1'b1;
          state_d      = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        delta_d = phase_q - phase_last_q;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        prod_d  = prod_shift[PHASE_WIDTH-1:0];
        k_out_d = (k_shift > K_SAT) ? K_SAT[ADDR_WIDTH-1:0] : k_shift[ADDR_WIDTH-1:0];
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        acc_d   = acc_q + prod_q;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // Output beats are registered: the first cycle here loads bin 0, then each handshake loads the next bin.
        if (!tvalid_q || (m_axis.m_tready && !tlast_q)) begin
          tvalid_d = 1'b1;
          tuser_d  = beat_bin;
          tdata_d  = beat_data;
          tlast_d  = (beat_bin == BIN_LAST);
        end else if (m_axis.m_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tuser_d  = '0;
          tdata_d  = '0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      phase_last_q <= '0;
      k_max_q      <= '0;
      mag_q        <= '0;
      ratio_q      <= '0;
      delta_q      <= '0;
      prod_q       <= '0;
      k_out_q      <= '0;
      acc_q        <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= '0;
      busy_q       <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      phase_last_q <= phase_last_d;
      k_max_q      <= k_max_d;
      mag_q        <= mag_d;
      ratio_q      <= ratio_d;
      delta_q      <= delta_d;
      prod_q       <= prod_d;
      k_out_q      <= k_out_d;
      acc_q        <= acc_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
    end
  end

  assign m_axis.m_tdata  = tdata_q;
  assign m_axis.m_tvalid = tvalid_q;
  assign m_axis.m_tlast  = tlast_q;
  assign m_axis.m_tuser  = 16'(tuser_q);
  assign busy            = busy_q;
  assign dropped_count   = drop_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_phase_synthesizer.sv
// Self-checking bench for phase_synthesizer: directed frames plus randomized frames against a frame-level model.
module tb_phase_synthesizer;
  localparam int N = 2048;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] phase, phase_last;
  logic        phases_valid;
  logic [10:0] k_max;
  logic [15:0] magnitude, pitch_ratio;
  logic        busy;
  logic [7:0]  dropped_count;
  logic [2:0]  dbg_state;

  phase_synthesizer_if axis ();

  phase_synthesizer dut (
    .clock(clock), .reset(reset), .phase(phase), .phase_last(phase_last),
    .phases_valid(phases_valid), .k_max(k_max), .magnitude(magnitude),
    .pitch_ratio(pitch_ratio), .m_axis(axis), .busy(busy),
    .dropped_count(dropped_count), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];
  logic [47:0] got_frame [N];
  logic [23:0] model_acc = '0;
  bit   model_busy = 0;
  int   exp_dropped = 0;
  int   ready_pct = 100;
  int   hs_count = 0;

  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Frame-level model: build every beat of the frame from the arithmetic rules.
  function automatic void model_capture(input logic [23:0] ph, input logic [23:0] phl,
                                        input logic [10:0] k, input logic [15:0] mag,
                                        input logic [15:0] ratio);
    longint d, p, kk;
    logic [23:0] diff, prod, phf;
    logic [47:0] w;
    diff = ph - phl;
    d = longint'(diff);
    if (d >= 64'sd8388608) d = d - 64'sd16777216;
    p = (d * longint'(ratio)) >>> 12;
    prod = p[23:0];
    kk = (longint'(k) * longint'(ratio)) >>> 12;
    if (kk > 1023) kk = 1023;
    model_acc = model_acc + prod;
    for (int b = 0; b < N; b++) begin
      w = '0;
      if (b == kk) begin
        phf = (kk == 0) ? 24'h0 : model_acc;
        w = {8'h00, mag, phf};
      end
`ifdef PHASE_SYNTH_HERMITIAN_EN
      if (kk != 0 && b == N - kk) begin
        phf = 24'h0 - model_acc;
        w = {8'h00, mag, phf};
      end
`endif
      exp_q.push_back({16'(b), (b == N - 1), w});
    end
    model_busy = 1;
  endfunction

  // Stream sink: random backpressure changed just after each rising edge.
  initial begin
    axis.m_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      axis.m_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Compare process: sampled on the falling edge, away from the active edge.
  logic [65:0] prev_beat;
  bit prev_stall = 0;
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", {axis.m_tvalid, axis.m_tuser, axis.m_tlast, axis.m_tdata}, prev_beat);
        if (!model_busy) check("idle_no_valid", 66'(axis.m_tvalid), 66'(0));
        if (axis.m_tvalid && axis.m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 66'(axis.m_tuser), 66'h3FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat", {1'b0, axis.m_tuser, axis.m_tlast, axis.m_tdata}, {1'b0, e});
          end
          got_frame[axis.m_tuser[10:0]] = axis.m_tdata;
          hs_count++;
          if (axis.m_tlast) model_busy = 0;
        end
        prev_stall = axis.m_tvalid && !axis.m_tready;
        prev_beat  = {axis.m_tvalid, axis.m_tuser, axis.m_tlast, axis.m_tdata};
      end
    end
  end

  // Drivers: called at one time unit after a rising edge, return at the same phase.
  task automatic pulse(input logic [23:0] ph, input logic [23:0] phl, input logic [10:0] k,
                       input logic [15:0] mag, input logic [15:0] ratio);
    phase = ph; phase_last = phl; k_max = k; magnitude = mag; pitch_ratio = ratio;
    phases_valid = 1'b1;
    if (!model_busy) begin
      hs_count = 0;
      model_capture(ph, phl, k, mag, ratio);
    end else if (exp_dropped < 255) begin
      exp_dropped++;
    end
    @(posedge clock);
    #1;
    phases_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (model_busy && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (model_busy) begin
      check("frame_timeout", 66'(model_busy), 66'(0));
      exp_q.delete();
      model_busy = 0;
    end
    check("busy_after_frame", 66'(busy), 66'(0));
    check("queue_drained", 66'(exp_q.size()), 66'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_tvalid", 66'(axis.m_tvalid), 66'(0));
    exp_q.delete();
    model_busy = 0;
    model_acc = '0;
    exp_dropped = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    phase = '0; phase_last = '0; phases_valid = 1'b0; k_max = '0; magnitude = '0; pitch_ratio = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_outputs", {axis.m_tvalid, axis.m_tlast, axis.m_tuser, axis.m_tdata},
          66'(0));
    check("rst_busy_drop", {busy, dropped_count}, 66'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Unity ratio, latency to first beat, bin 10.
    pulse(24'h000400, 24'h000100, 11'd10, 16'h1234, 16'h1000);
    check("lat_e0", 66'(axis.m_tvalid), 66'(0));
    for (int i = 1; i < 4; i++) begin
      @(posedge clock);
      #1;
      check("lat_early", 66'(axis.m_tvalid), 66'(0));
    end
    @(posedge clock);
    #1;
    check("lat_e4", 66'(axis.m_tvalid), 66'(1));
    check("busy_in_frame", 66'(busy), 66'(1));
    wait_idle(5000);
    check("t1_bin10", 66'(got_frame[10]), 66'(48'h001234_000300));
    check("t1_bin11", 66'(got_frame[11]), 66'(0));
    check("t1_hs", 66'(hs_count), 66'(N));
`ifdef PHASE_SYNTH_HERMITIAN_EN
    check("t1_mirror", 66'(got_frame[2038]), 66'(48'h001234_FFFD00));
`else
    check("t1_mirror", 66'(got_frame[2038]), 66'(0));
`endif

    // Ratio 2.0 with accumulation across frames.
    do_reset();
    pulse(24'h000300, 24'h000000, 11'd10, 16'h0055, 16'h2000);
    wait_idle(5000);
    check("t2_f1", 66'(got_frame[20]), 66'(48'h000055_000600));
    pulse(24'h000300, 24'h000000, 11'd10, 16'h0055, 16'h2000);
    wait_idle(5000);
    check("t2_f2", 66'(got_frame[20]), 66'(48'h000055_000C00));

    // Phase wrap, bin saturation, k_out==0.
    do_reset();
    pulse(24'h800100, 24'h7FFF00, 11'd5, 16'h0077, 16'h1000);
    wait_idle(5000);
    check("t3_wrap", 66'(got_frame[5]), 66'(48'h000077_000200));
    pulse(24'h000100, 24'h000000, 11'd1500, 16'h0099, 16'h2000);
    wait_idle(5000);
    check("t3_sat", 66'(got_frame[1023]), 66'(48'h000099_000400));
    pulse(24'h000100, 24'h000000, 11'd1, 16'h00AB, 16'h0800);
    wait_idle(5000);
    check("t3_k0", 66'(got_frame[0]), 66'(48'h0000AB_000000));

    // Random backpressure with a negative delta.
    ready_pct = 50;
    pulse(24'h000100, 24'h000900, 11'd33, 16'hBEEF, 16'h1800);
    wait_idle(10000);
    check("t4_hs", 66'(hs_count), 66'(N));

    // Strobes while streaming are dropped.
    ready_pct = 100;
    pulse(24'h001000, 24'h000800, 11'd100, 16'h4242, 16'h1000);
    repeat (10) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) pulse(24'hFFFFFF, 24'h0, 11'd7, 16'hFFFF, 16'hFFFF);
    wait_idle(5000);
    check("t5_drop_model", 66'(dropped_count), 66'(exp_dropped));
    check("t5_drop_lit", 66'(dropped_count), 66'(3));

    // Reset mid-frame, then a clean frame.
    pulse(24'h002000, 24'h000000, 11'd50, 16'h1111, 16'h1000);
    n = 0;
    while (hs_count < 500 && n < 5000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("t6_reach_500", 66'(hs_count >= 500), 66'(1));
    do_reset();
    pulse(24'h000500, 24'h000100, 11'd7, 16'h2222, 16'h1000);
    wait_idle(5000);
    check("t6_acc", 66'(got_frame[7]), 66'(48'h002222_000400));

    // Randomized frames with random backpressure and stray strobes.
    for (int f = 0; f < 5; f++) begin
      ready_pct = $urandom_range(100, 30);
      pulse(24'($urandom), 24'($urandom), 11'($urandom), 16'($urandom), 16'($urandom_range(16'h4000)));
      repeat ($urandom_range(40, 5)) @(posedge clock);
      #1;
      if ($urandom_range(1)) pulse(24'($urandom), 24'($urandom), 11'($urandom), 16'($urandom), 16'($urandom));
      wait_idle(12000);
    end
    check("final_drop", 66'(dropped_count), 66'(exp_dropped));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
